pixel_wr_arbiter: RTL and testbench

- Sequences and shares the single write port of the 64-entry x 12-bit pixel RAM that feeds the VGA colour path.
- Three write sources: CPU MMIO pixel writes (buffered in a small FIFO), keyboard-cursor paint requests, and an internal full-screen clear sequencer.
- Issues at most one registered RAM write per cycle and sits between the bus-decode logic and the pixel RAM write port.

---
 rtl/pixel_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_pixel_wr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_wr_arbiter : shares the pixel RAM write port between a CPU FIFO,   |
// |                    keyboard cursor paints and a full-screen clear.       |
// | Optional: BLANK_ONLY_WR_EN restricts writes to blank cycles.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_wr_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  kbd_req_valid,
  output logic                  kbd_req_ready,
  input  logic [ADDR_WIDTH-1:0] kbd_addr,
  input  logic [DATA_WIDTH-1:0] kbd_data,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_color,
  input  logic                  blank,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_CLR_LAST = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

  typedef enum logic [0:0] {S_ARB = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                         r_state, w_state_nxt;
  logic                           r_last_kbd;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]                 r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]            r_clr_cnt;
  logic [DATA_WIDTH-1:0]          r_clr_color;
  logic                           r_ram_we, r_clear_done;
  logic [ADDR_WIDTH-1:0]          r_ram_waddr;
  logic [DATA_WIDTH-1:0]          r_ram_wdata;

  logic w_full, w_empty, w_push, w_en;
  logic w_gnt_cpu, w_gnt_kbd, w_clr_wr, w_clr_start, w_clr_last;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_fifo_head;

`ifdef BLANK_ONLY_WR_EN
  assign w_en = blank;
`else
  logic w_blank_unused;
  assign w_blank_unused = blank;
  assign w_en           = 1'b1;
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_empty     = (r_wptr == r_rptr);
  assign w_push      = cpu_req_valid & ~w_full;
  assign w_fifo_head = r_fifo[r_rptr[PTR_W-1:0]];

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_cpu   = 1'b0;
    w_gnt_kbd   = 1'b0;
    w_clr_wr    = 1'b0;
    w_clr_start = 1'b0;
    case (r_state)
      S_ARB: begin
        if (clear_start) begin
          w_clr_start = 1'b1;
          w_state_nxt = S_CLEAR;
        end else if (w_en) begin
          if (!w_empty && kbd_req_valid) begin
            w_gnt_cpu = r_last_kbd;
            w_gnt_kbd = ~r_last_kbd;
          end else if (!w_empty) begin
            w_gnt_cpu = 1'b1;
          end else if (kbd_req_valid) begin
            w_gnt_kbd = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (w_en) begin
          w_clr_wr = 1'b1;
          if (r_clr_cnt == c_CLR_LAST) w_state_nxt = S_ARB;
        end
      end
      default: w_state_nxt = S_ARB;
    endcase
  end

  assign w_clr_last = w_clr_wr && (r_clr_cnt == c_CLR_LAST);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PTR_W-1:0]] <= {cpu_addr, cpu_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_ARB;
      r_last_kbd   <= 1'b1;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_clr_cnt    <= '0;
      r_clr_color  <= '0;
      r_ram_we     <= 1'b0;
      r_ram_waddr  <= '0;
      r_ram_wdata  <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push)    r_wptr <= r_wptr + 1'b1;
      if (w_gnt_cpu) r_rptr <= r_rptr + 1'b1;
      if (w_gnt_cpu)      r_last_kbd <= 1'b0;
      else if (w_gnt_kbd) r_last_kbd <= 1'b1;
      if (w_clr_start) begin
        r_clr_cnt   <= '0;
        r_clr_color <= clear_color;
      end else if (w_clr_wr) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
      r_ram_we <= w_gnt_cpu | w_gnt_kbd | w_clr_wr;
      if (w_gnt_cpu) begin
        {r_ram_waddr, r_ram_wdata} <= w_fifo_head;
      end else if (w_gnt_kbd) begin
        r_ram_waddr <= kbd_addr;
        r_ram_wdata <= kbd_data;
      end else if (w_clr_wr) begin
        r_ram_waddr <= r_clr_cnt[ADDR_WIDTH-1:0];
        r_ram_wdata <= r_clr_color;
      end
      r_clear_done <= w_clr_last;
    end
  end

  // Grant is combinational, so mask it while reset holds the FSM.
  assign kbd_req_ready = w_gnt_kbd & ~reset;
  assign cpu_req_ready = ~w_full;
  assign busy          = (r_state == S_CLEAR);
  assign ram_we        = r_ram_we;
  assign ram_waddr     = r_ram_waddr;
  assign ram_wdata     = r_ram_wdata;
  assign clear_done    = r_clear_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_wr_arbiter : vector table, directed corner sequences and random |
// |                       traffic against a queue-based reference model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pixel_wr_arbiter;

  localparam int AW = 6;
  localparam int DW = 12;
  localparam int DEPTH = 4;
  localparam int NWORDS = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  logic cpu_req_valid, cpu_req_ready, kbd_req_valid, kbd_req_ready;
  logic [AW-1:0] cpu_addr, kbd_addr, ram_waddr;
  logic [DW-1:0] cpu_data, kbd_data, clear_color, ram_wdata;
  logic clear_start, blank, ram_we, busy, clear_done;

  pixel_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .kbd_req_valid(kbd_req_valid), .kbd_req_ready(kbd_req_ready),
    .kbd_addr(kbd_addr), .kbd_data(kbd_data),
    .clear_start(clear_start), .clear_color(clear_color), .blank(blank),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending CPU writes in a queue, clear as a plain counter.
  logic [AW+DW-1:0] m_q[$];
  bit m_last_kbd, m_clear, m_we, m_done, m_kbd_rdy, m_cpu_gnt;
  int m_cnt;
  logic [DW-1:0] m_color, m_data;
  logic [AW-1:0] m_addr;

  logic [AW+DW-1:0] wr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_en();
`ifdef BLANK_ONLY_WR_EN
    return blank;
`else
    return 1'b1;
`endif
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_last_kbd = 1; m_clear = 0; m_cnt = 0; m_color = '0;
    m_we = 0; m_addr = '0; m_data = '0; m_done = 0; m_kbd_rdy = 0; m_cpu_gnt = 0;
  endtask

  task automatic m_decide();
    m_kbd_rdy = 0;
    m_cpu_gnt = 0;
    if (!m_clear && !clear_start && m_en()) begin
      if (m_q.size() > 0 && kbd_req_valid) begin
        if (m_last_kbd) m_cpu_gnt = 1; else m_kbd_rdy = 1;
      end else if (m_q.size() > 0) m_cpu_gnt = 1;
      else if (kbd_req_valid)   m_kbd_rdy = 1;
    end
  endtask

  task automatic m_commit();
    bit can_push;
    can_push = (m_q.size() < DEPTH);
    m_we = 0;
    m_done = 0;
    if (m_clear) begin
      if (m_en()) begin
        m_we = 1; m_addr = AW'(m_cnt); m_data = m_color;
        if (m_cnt == NWORDS - 1) begin m_clear = 0; m_done = 1; end
        m_cnt++;
      end
    end else if (clear_start) begin
      m_clear = 1; m_cnt = 0; m_color = clear_color;
    end else if (m_cpu_gnt) begin
      {m_addr, m_data} = m_q.pop_front(); m_we = 1; m_last_kbd = 0;
    end else if (m_kbd_rdy) begin
      m_addr = kbd_addr; m_data = kbd_data; m_we = 1; m_last_kbd = 1;
    end
    if (cpu_req_valid && can_push) m_q.push_back({cpu_addr, cpu_data});
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    m_decide();
    chk("cpu_req_ready", cpu_req_ready, 32'(m_q.size() < DEPTH));
    chk("kbd_req_ready", kbd_req_ready, 32'(m_kbd_rdy));
    chk("busy", busy, 32'(m_clear));
    @(posedge clk);
    m_commit();
    @(negedge clk);
    chk("ram_we", ram_we, 32'(m_we));
    chk("ram_waddr", ram_waddr, 32'(m_addr));
    chk("ram_wdata", ram_wdata, 32'(m_data));
    chk("clear_done", clear_done, 32'(m_done));
    if (ram_we) wr_log.push_back({ram_waddr, ram_wdata});
  endtask

  task automatic idle_inputs();
    cpu_req_valid = 0; cpu_addr = '0; cpu_data = '0;
    kbd_req_valid = 0; kbd_addr = '0; kbd_data = '0;
    clear_start = 0; clear_color = '0; blank = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    kbd_req_valid = 1;
    reset = 1;
    m_reset();
    wr_log.delete();
    repeat (2) @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_waddr", ram_waddr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_kbd_ready", kbd_req_ready, 0);
    chk("rst_cpu_ready", cpu_req_ready, 1);
    kbd_req_valid = 0;
    reset = 0;
  endtask

  typedef struct {
    logic cv; logic [AW-1:0] ca; logic [DW-1:0] cd;
    logic kv; logic [AW-1:0] ka; logic [DW-1:0] kd;
    logic e_crdy; logic e_krdy;
    logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int busy_cnt, clr_wr, clr_ok, done_cnt, done_iter, kbd_iter, iter, guard;
    logic [AW+DW-1:0] w;

    vecs[0] = '{1'b1, 6'd5, 12'hF00, 1'b0, 6'd0,  12'h000, 1'b1, 1'b0, 1'b0, 6'd0,  12'h000};
    vecs[1] = '{1'b0, 6'd0, 12'h000, 1'b0, 6'd0,  12'h000, 1'b1, 1'b0, 1'b1, 6'd5,  12'hF00};
    vecs[2] = '{1'b0, 6'd0, 12'h000, 1'b0, 6'd0,  12'h000, 1'b1, 1'b0, 1'b0, 6'd5,  12'hF00};
    vecs[3] = '{1'b0, 6'd0, 12'h000, 1'b1, 6'd9,  12'h0F0, 1'b1, 1'b1, 1'b1, 6'd9,  12'h0F0};
    vecs[4] = '{1'b1, 6'd7, 12'h123, 1'b0, 6'd0,  12'h000, 1'b1, 1'b0, 1'b0, 6'd9,  12'h0F0};
    vecs[5] = '{1'b1, 6'd8, 12'h456, 1'b1, 6'd10, 12'h00F, 1'b1, 1'b0, 1'b1, 6'd7,  12'h123};
    vecs[6] = '{1'b0, 6'd0, 12'h000, 1'b1, 6'd10, 12'h00F, 1'b1, 1'b1, 1'b1, 6'd10, 12'h00F};
    vecs[7] = '{1'b0, 6'd0, 12'h000, 1'b0, 6'd0,  12'h000, 1'b1, 1'b0, 1'b1, 6'd8,  12'h456};
    vecs[8] = '{1'b0, 6'd0, 12'h000, 1'b0, 6'd0,  12'h000, 1'b1, 1'b0, 1'b0, 6'd8,  12'h456};

    idle_inputs();
    reset = 1;
    @(negedge clk);
    do_reset();

    // Vector table: single CPU write, KBD write, tie-break after a KBD grant.
    foreach (vecs[i]) begin
      cpu_req_valid = vecs[i].cv; cpu_addr = vecs[i].ca; cpu_data = vecs[i].cd;
      kbd_req_valid = vecs[i].kv; kbd_addr = vecs[i].ka; kbd_data = vecs[i].kd;
      #1;
      chk($sformatf("vec%0d_cpu_ready", i), cpu_req_ready, 32'(vecs[i].e_crdy));
      chk($sformatf("vec%0d_kbd_ready", i), kbd_req_ready, 32'(vecs[i].e_krdy));
      cycle();
      chk($sformatf("vec%0d_we", i), ram_we, 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_addr", i), ram_waddr, 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d_data", i), ram_wdata, 32'(vecs[i].e_data));
    end

    // Fill FIFO during a clear, then round-robin against a held KBD stream.
    do_reset();
    clear_start = 1; clear_color = 12'h000;
    kbd_req_valid = 1; kbd_addr = 6'h30; kbd_data = 12'hABC;
    cycle();
    clear_start = 0;
    for (int i = 1; i <= 5; i++) begin
      cpu_req_valid = 1; cpu_addr = AW'(i); cpu_data = DW'(12'h100 + i);
      if (i == 5) begin #1; chk("fifo_full_ready", cpu_req_ready, 0); end
      cycle();
    end
    cpu_req_valid = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_kbd_rdy) kbd_addr = kbd_addr + 1'b1;
      cycle();
    end
    kbd_req_valid = 0;
    chk("rr_write_count_min", 32'(wr_log.size() >= NWORDS + 8), 1);
    for (int j = 0; j < 8; j++) begin
      w = (wr_log.size() > NWORDS + j) ? wr_log[NWORDS + j] : '0;
      if (j % 2 == 0) begin
        chk($sformatf("rr_cpu_addr%0d", j), 32'(w[AW+DW-1:DW]), j / 2 + 1);
        chk($sformatf("rr_cpu_data%0d", j), 32'(w[DW-1:0]), 12'h100 + j / 2 + 1);
      end else begin
        chk($sformatf("rr_kbd_data%0d", j), 32'(w[DW-1:0]), 12'hABC);
      end
    end

    // Clear with a pending KBD request.
    do_reset();
    clear_start = 1; clear_color = 12'h0A5;
    kbd_req_valid = 1; kbd_addr = 6'd3; kbd_data = 12'h777;
    cycle();
    clear_start = 0;
    busy_cnt = busy ? 1 : 0;
    clr_wr = 0; clr_ok = 0; done_cnt = 0; done_iter = -1; kbd_iter = -1;
    for (iter = 0; iter < 70; iter++) begin
      if (m_kbd_rdy) kbd_req_valid = 0;
      cycle();
      if (busy) busy_cnt++;
      if (clear_done) begin done_cnt++; done_iter = iter; end
      if (ram_we && ram_wdata == 12'h0A5) begin
        if (ram_waddr == AW'(clr_wr)) clr_ok++;
        clr_wr++;
      end
      if (ram_we && ram_waddr == 6'd3 && ram_wdata == 12'h777) kbd_iter = iter;
    end
    chk("clear_busy_cycles", busy_cnt, NWORDS);
    chk("clear_write_count", clr_wr, NWORDS);
    chk("clear_addr_order", clr_ok, NWORDS);
    chk("clear_done_count", done_cnt, 1);
    chk("clear_kbd_after_done", kbd_iter, done_iter + 1);

    // Reset asserted part-way through a clear.
    do_reset();
    clear_start = 1; clear_color = 12'h5A5;
    cycle();
    clear_start = 0;
    guard = 0;
    while (!(ram_we && ram_waddr == 6'd20) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("clear_reached_addr20", 32'(guard < 100), 1);
    #2 reset = 1;
    #1;
    chk("midclr_ram_we", ram_we, 0);
    chk("midclr_busy", busy, 0);
    chk("midclr_cpu_ready", cpu_req_ready, 1);
    chk("midclr_clear_done", clear_done, 0);
    m_reset();
    @(negedge clk);
    reset = 0;
    done_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      cycle();
      if (clear_done) done_cnt++;
    end
    chk("midclr_no_done", done_cnt, 0);

    // Blank gating of a held KBD request.
    do_reset();
    blank = 0;
    kbd_req_valid = 1; kbd_addr = 6'h11; kbd_data = 12'h321;
`ifdef BLANK_ONLY_WR_EN
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("blank0_kbd_ready", kbd_req_ready, 0);
      cycle();
      chk("blank0_ram_we", ram_we, 0);
    end
    blank = 1;
    #1;
    chk("blank1_kbd_ready", kbd_req_ready, 1);
    cycle();
`else
    #1;
    chk("noblank_kbd_ready", kbd_req_ready, 1);
    cycle();
`endif
    chk("blank_ram_we", ram_we, 1);
    chk("blank_ram_waddr", ram_waddr, 6'h11);
    kbd_req_valid = 0;
    blank = 1;
    cycle();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      cpu_req_valid = 1'($urandom_range(0, 1));
      cpu_addr = AW'($urandom);
      cpu_data = DW'($urandom);
      if (!kbd_req_valid || m_kbd_rdy) begin
        kbd_req_valid = 1'($urandom_range(0, 1));
        kbd_addr = AW'($urandom);
        kbd_data = DW'($urandom);
      end
      clear_start = ($urandom_range(0, 199) == 0);
      clear_color = DW'($urandom);
`ifdef BLANK_ONLY_WR_EN
      blank = ($urandom_range(0, 3) != 0);
`else
      blank = 1'($urandom_range(0, 1));
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
